cmos_rgb565_capture: RTL and testbench

Byte-to-pixel capture stage that sits between the camera sensor interface and the DDR frame-buffer write port inside the camera path. It samples the sensor's 8-bit parallel bus, pairs bytes into RGB565 pixels, discards a programmable number of settling frames after reset, and produces pixel coordinates plus frame and line status strobes for the frame-buffer writer. It runs entirely in the sensor pixel-clock domain.

---
 rtl/cmos_rgb565_capture.sv | 156 +++++++++++++++
 tb/tb_cmos_rgb565_capture.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_rgb565_capture.sv
// Sensor byte-to-RGB565 pixel capture in the pixel-clock domain: skips settling
// frames after reset, pairs bytes into pixels and reports coordinates and line errors.
module cmos_rgb565_capture #(
  parameter int IMG_WIDTH  = 1280,
  parameter int FRAME_SKIP = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_db,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        frame_start,
  output logic        capture_en,
  output logic        line_err
);

  localparam logic [15:0] SKIP_W  = 16'(FRAME_SKIP);
  localparam logic [10:0] WIDTH_W = 11'(IMG_WIDTH);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  logic        vsync_d1_q, vsync_d1_d, vsync_d2_q, vsync_d2_d;
  logic        href_d1_q, href_d1_d, href_d2_q, href_d2_d;
  logic [7:0]  db_d1_q, db_d1_d, hi_byte_q, hi_byte_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        capture_en_q, capture_en_d, armed_q, armed_d;
  logic        byte_phase_q, byte_phase_d, line_abort_q, line_abort_d;
  logic [10:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        frame_start_q, frame_start_d, line_err_q, line_err_d;

  logic vs_rise, href_fall, abort, emit;

  always_comb begin
    vs_rise   = vsync_d1_q & ~vsync_d2_q;
    href_fall = ~href_d1_q & href_d2_q;
    abort     = vs_rise & href_d1_q;
    // Nothing is emitted for the rest of a line cut by vsync.
    emit      = href_d1_q & byte_phase_q & armed_q & ~vs_rise & ~line_abort_q;

    vsync_d1_d    = cmos_vsync;
    vsync_d2_d    = vsync_d1_q;
    href_d1_d     = cmos_href;
    href_d2_d     = href_d1_q;
    db_d1_d       = cmos_db;
    hi_byte_d     = hi_byte_q;
    frame_cnt_d   = frame_cnt_q;
    armed_d       = armed_q;
    byte_phase_d  = byte_phase_q;
    line_abort_d  = line_abort_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    pix_data_d    = pix_data_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = 1'b0;
    line_err_d    = 1'b0;

    if (vs_rise && frame_cnt_q != SKIP_W) frame_cnt_d = frame_cnt_q + 16'd1;
    capture_en_d = (frame_cnt_d == SKIP_W);

    // Arming only on a frame boundary guarantees the first captured frame is whole.
    if (vs_rise && capture_en_q) armed_d = 1'b1;
    frame_start_d = vs_rise & (armed_q | capture_en_q);

    if (href_d1_q) begin
      byte_phase_d = ~byte_phase_q;
      if (!byte_phase_q) hi_byte_d = db_d1_q;
    end else begin
      byte_phase_d = 1'b0;
    end

    if (emit) begin
      pix_valid_d = 1'b1;
      pix_data_d  = {hi_byte_q, db_d1_q};
      pix_x_d     = x_cnt_q;
      pix_y_d     = y_cnt_q;
      if (x_cnt_q != CNT_MAX) x_cnt_d = x_cnt_q + 11'd1;
    end
    if (!href_d1_q) x_cnt_d = 11'd0;

    if (href_fall) begin
      if (x_cnt_q != 11'd0 && y_cnt_q != CNT_MAX) y_cnt_d = y_cnt_q + 11'd1;
      if (armed_q && !line_abort_q && (x_cnt_q != WIDTH_W || byte_phase_q))
        line_err_d = 1'b1;
    end

    if (abort)           line_abort_d = 1'b1;
    else if (!href_d1_q) line_abort_d = 1'b0;

    if (vs_rise) y_cnt_d = 11'd0;
    if (abort) begin
      x_cnt_d      = 11'd0;
      byte_phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1_q    <= 1'b0;
      vsync_d2_q    <= 1'b0;
      href_d1_q     <= 1'b0;
      href_d2_q     <= 1'b0;
      db_d1_q       <= 8'd0;
      hi_byte_q     <= 8'd0;
      frame_cnt_q   <= 16'd0;
      capture_en_q  <= 1'b0;
      armed_q       <= 1'b0;
      byte_phase_q  <= 1'b0;
      line_abort_q  <= 1'b0;
      x_cnt_q       <= 11'd0;
      y_cnt_q       <= 11'd0;
      pix_data_q    <= 16'd0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 11'd0;
      pix_y_q       <= 11'd0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      vsync_d1_q    <= vsync_d1_d;
      vsync_d2_q    <= vsync_d2_d;
      href_d1_q     <= href_d1_d;
      href_d2_q     <= href_d2_d;
      db_d1_q       <= db_d1_d;
      hi_byte_q     <= hi_byte_d;
      frame_cnt_q   <= frame_cnt_d;
      capture_en_q  <= capture_en_d;
      armed_q       <= armed_d;
      byte_phase_q  <= byte_phase_d;
      line_abort_q  <= line_abort_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      line_err_q    <= line_err_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign capture_en  = capture_en_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Directed bench for cmos_rgb565_capture with FRAME_SKIP = 2 and IMG_WIDTH = 4.
module tb_cmos_rgb565_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_db = 8'd0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        frame_start;
  logic        capture_en;
  logic        line_err;

  cmos_rgb565_capture #(.IMG_WIDTH(4), .FRAME_SKIP(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_db(cmos_db), .pix_data(pix_data), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .frame_start(frame_start), .capture_en(capture_en), .line_err(line_err)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  // Observed-event log, sampled on the falling edge
  logic [15:0] pd_q[$];
  int          px_q[$];
  int          py_q[$];
  int          pc_q[$];
  int          fs_cnt = 0;
  int          le_cnt = 0;
  int          le_cyc = 0;
  int          b2b = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (pix_valid) begin
      pd_q.push_back(pix_data);
      px_q.push_back(int'(pix_x));
      py_q.push_back(int'(pix_y));
      pc_q.push_back(cyc);
      if (prev_valid) b2b++;
    end
    prev_valid = pix_valid;
    if (frame_start) fs_cnt++;
    if (line_err) begin
      le_cnt++;
      le_cyc = cyc;
    end
  end

  task automatic clear_log();
    pd_q.delete();
    px_q.delete();
    py_q.delete();
    pc_q.delete();
    fs_cnt = 0;
    le_cnt = 0;
    b2b    = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input int i, input logic [15:0] d, input int x, input int y);
    check($sformatf("pix%0d_data", i), 32'(pd_q[i]), 32'(d));
    check($sformatf("pix%0d_x", i), 32'(px_q[i]), 32'(x));
    check($sformatf("pix%0d_y", i), 32'(py_q[i]), 32'(y));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix_data"}, 32'(pix_data), 32'h0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'h0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'h0);
    check({tag, "_pix_y"}, 32'(pix_y), 32'h0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'h0);
    check({tag, "_capture_en"}, 32'(capture_en), 32'h0);
    check({tag, "_line_err"}, 32'(line_err), 32'h0);
  endtask

  // Driver tasks (inputs change on the falling edge)
  logic [7:0] line_buf[16];

  task automatic fill_line(input logic [7:0] base);
    for (int i = 0; i < 16; i++) line_buf[i] = base + 8'(i);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    cmos_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cmos_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_line(input int n, output int fall_edge, output int first_edge);
    first_edge = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmos_href = 1'b1;
      cmos_db   = line_buf[i];
      if (i == 0) first_edge = cyc + 1;
    end
    @(negedge clk);
    cmos_href = 1'b0;
    cmos_db   = 8'd0;
    fall_edge = cyc + 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame();
    int fe, fst;
    vsync_pulse();
    fill_line(8'h10);
    send_line(8, fe, fst);
    fill_line(8'h20);
    send_line(8, fe, fst);
  endtask

  task automatic check_full_frame(input string tag);
    logic [7:0] b;
    check({tag, "_frame_start_cnt"}, 32'(fs_cnt), 32'd1);
    check({tag, "_pix_cnt"}, 32'(pd_q.size()), 32'd8);
    check({tag, "_line_err_cnt"}, 32'(le_cnt), 32'd0);
    check({tag, "_back_to_back"}, 32'(b2b), 32'd0);
    if (pd_q.size() == 8) begin
      for (int l = 0; l < 2; l++) begin
        for (int k = 0; k < 4; k++) begin
          b = 8'h10 * 8'(l + 1) + 8'(2 * k);
          check_pix(l * 4 + k, {b, b + 8'd1}, k, l);
        end
      end
    end
  endtask

  initial begin
    int fe, fst;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two settling frames are discarded
    clear_log();
    run_frame();
    check("skip1_capture_en", 32'(capture_en), 32'd0);
    run_frame();
    check("skip2_capture_en", 32'(capture_en), 32'd1);
    check("skip_pix_cnt", 32'(pd_q.size()), 32'd0);
    check("skip_frame_start_cnt", 32'(fs_cnt), 32'd0);

    // Third frame is captured whole
    clear_log();
    run_frame();
    check_full_frame("frame3");

    // Byte order and pixel latency
    clear_log();
    vsync_pulse();
    fill_line(8'h00);
    line_buf[0] = 8'hF8;
    line_buf[1] = 8'h1F;
    send_line(8, fe, fst);
    check("order_frame_start_cnt", 32'(fs_cnt), 32'd1);
    check("order_pix_cnt", 32'(pd_q.size()), 32'd4);
    check_pix(0, 16'hF81F, 0, 0);
    check("order_latency", 32'(pc_q[0]), 32'(fst + 2));
    check("order_line_err_cnt", 32'(le_cnt), 32'd0);

    // Odd-length line: orphan byte dropped, line_err one cycle after href_d1 falls
    clear_log();
    fill_line(8'h40);
    send_line(7, fe, fst);
    check("odd_pix_cnt", 32'(pd_q.size()), 32'd3);
    check_pix(0, 16'h4041, 0, 1);
    check_pix(2, 16'h4445, 2, 1);
    check("odd_line_err_cnt", 32'(le_cnt), 32'd1);
    check("odd_line_err_cyc", 32'(le_cyc), 32'(fe + 1));

    // Short line, then a good line continues on the next row
    clear_log();
    fill_line(8'h50);
    send_line(6, fe, fst);
    check("short_pix_cnt", 32'(pd_q.size()), 32'd3);
    check_pix(2, 16'h5455, 2, 2);
    check("short_line_err_cnt", 32'(le_cnt), 32'd1);
    clear_log();
    fill_line(8'h60);
    send_line(8, fe, fst);
    check("next_pix_cnt", 32'(pd_q.size()), 32'd4);
    check_pix(0, 16'h6061, 0, 3);
    check_pix(3, 16'h6667, 3, 3);
    check("next_line_err_cnt", 32'(le_cnt), 32'd0);

    // vsync rising in the middle of a line
    clear_log();
    fill_line(8'h70);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmos_href = 1'b1;
      cmos_db   = line_buf[i];
    end
    @(negedge clk);
    cmos_vsync = 1'b1;
    cmos_db    = line_buf[3];
    @(negedge clk);
    cmos_href = 1'b0;
    cmos_db   = 8'd0;
    repeat (2) @(negedge clk);
    cmos_vsync = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_pix_cnt", 32'(pd_q.size()), 32'd1);
    check_pix(0, 16'h7071, 0, 4);
    check("abort_line_err_cnt", 32'(le_cnt), 32'd0);
    check("abort_frame_start_cnt", 32'(fs_cnt), 32'd1);
    clear_log();
    fill_line(8'h80);
    send_line(8, fe, fst);
    check("after_abort_pix_cnt", 32'(pd_q.size()), 32'd4);
    check_pix(0, 16'h8081, 0, 0);
    check("after_abort_line_err_cnt", 32'(le_cnt), 32'd0);

    // Asynchronous reset in the middle of a captured line
    vsync_pulse();
    fill_line(8'h90);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmos_href = 1'b1;
      cmos_db   = line_buf[i];
    end
    @(posedge clk);
    #2;
    check("pre_reset_pix_valid", 32'(pix_valid), 32'd1);
    check("pre_reset_pix_data", 32'(pix_data), 32'h9293);
    rst_n     = 1'b0;
    cmos_href = 1'b0;
    cmos_db   = 8'd0;
    #1;
    check_outputs_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_capture_en", 32'(capture_en), 32'd0);

    clear_log();
    run_frame();
    run_frame();
    check("reskip_pix_cnt", 32'(pd_q.size()), 32'd0);
    check("reskip_frame_start_cnt", 32'(fs_cnt), 32'd0);
    check("reskip_capture_en", 32'(capture_en), 32'd1);
    clear_log();
    run_frame();
    check_full_frame("recapture");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
